// File: rtl/jtkunio_romarb_pkg.sv
// jtkunio_romarb_pkg: shared types and constants for the graphics ROM arbiter
package jtkunio_romarb_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;
    typedef enum logic {REQ_A, REQ_B} req_t;
    localparam logic [7:0] WDOG_MAX = 8'd255;
endpackage

// File: rtl/jtkunio_romarb_slot.sv
// jtkunio_romarb_slot: per-requester result register with address-matched ok
module jtkunio_romarb_slot #(
    parameter int AW = 18,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          ld,
    input  logic [AW-1:0] ld_tag,
    input  logic [DW-1:0] ld_data,
    output logic          ok,
    output logic [DW-1:0] data,
    output logic          pend
);
    logic [AW-1:0] tag;
    logic          valid;

    // ok is combinational so it falls in the very cycle the address moves
    assign ok   = cs & valid & (addr == tag);
    assign pend = cs & ~ok;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            tag   <= '0;
            data  <= '0;
            valid <= 1'b0;
        end else begin
            valid <= cs & (ld | valid);
            if (ld) begin
                tag  <= ld_tag;
                data <= ld_data;
            end
        end
endmodule

// File: rtl/jtkunio_romarb.sv
// jtkunio_romarb: round-robin sharing of one graphics ROM slot between two requesters
// Optional watchdog on stalled transfers: define JTKUNIO_ROMARB_WDOG_EN
module jtkunio_romarb
    import jtkunio_romarb_pkg::*;
#(
    parameter int AW = 18,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_cs,
    input  logic [AW-1:0] a_addr,
    output logic          a_ok,
    output logic [DW-1:0] a_data,
    input  logic          b_cs,
    input  logic [AW-1:0] b_addr,
    output logic          b_ok,
    output logic [DW-1:0] b_data,
    output logic          rom_cs,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    input  logic          rom_ok,
    output logic          err
);
    state_t st;
    req_t   gnt, last;
    logic   pend_a, pend_b, pick_b, wd_to, ld_a, ld_b;

    assign ld_a   = (st == BUSY) & rom_ok & (gnt == REQ_A);
    assign ld_b   = (st == BUSY) & rom_ok & (gnt == REQ_B);
    assign pick_b = pend_b & (~pend_a | (last == REQ_A));

    jtkunio_romarb_slot #(.AW(AW), .DW(DW)) u_a (
        .clk(clk), .rst(rst), .cs(a_cs), .addr(a_addr), .ld(ld_a),
        .ld_tag(rom_addr), .ld_data(rom_data), .ok(a_ok), .data(a_data), .pend(pend_a)
    );

    jtkunio_romarb_slot #(.AW(AW), .DW(DW)) u_b (
        .clk(clk), .rst(rst), .cs(b_cs), .addr(b_addr), .ld(ld_b),
        .ld_tag(rom_addr), .ld_data(rom_data), .ok(b_ok), .data(b_data), .pend(pend_b)
    );

`ifdef JTKUNIO_ROMARB_WDOG_EN
    logic [7:0] cnt;
    assign wd_to = (st == BUSY) & ~rom_ok & (cnt == WDOG_MAX);
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            cnt <= (st == BUSY) ? cnt + 8'd1 : 8'd0;
            if (wd_to) err <= 1'b1;
        end
`else
    assign wd_to = 1'b0;
    assign err   = 1'b0;
`endif

    // a transfer in flight always finishes; GAP gives the controller a fresh cs edge
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            st       <= IDLE;
            gnt      <= REQ_A;
            last     <= REQ_B;
            rom_cs   <= 1'b0;
            rom_addr <= '0;
        end else begin
            case (st)
                IDLE: if (pend_a | pend_b) begin
                    gnt      <= pick_b ? REQ_B : REQ_A;
                    rom_addr <= pick_b ? b_addr : a_addr;
                    rom_cs   <= 1'b1;
                    st       <= BUSY;
                end
                BUSY: if (rom_ok | wd_to) begin
                    rom_cs <= 1'b0;
                    last   <= gnt;
                    st     <= GAP;
                end
                default: st <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_jtkunio_romarb.sv
// tb_jtkunio_romarb: directed and randomized checks against a transaction-level model
module tb_jtkunio_romarb;
    localparam int AW = 18;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_cs = 1'b0, b_cs = 1'b0, rom_ok = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] rom_data = '0;
    logic          a_ok, b_ok, rom_cs, err;
    logic [DW-1:0] a_data, b_data;
    logic [AW-1:0] rom_addr;

    int checks = 0, errors = 0;
    bit checking = 0;

    always #5 clk = ~clk;

    jtkunio_romarb #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .a_cs(a_cs), .a_addr(a_addr), .a_ok(a_ok), .a_data(a_data),
        .b_cs(b_cs), .b_addr(b_addr), .b_ok(b_ok), .b_data(b_data),
        .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok),
        .err(err)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference: what each requester holds, whether the shared port is busy,
    // and how many idle cycles must pass before the next grant
    logic [AW-1:0] m_tag [2];
    logic [DW-1:0] m_dat [2];
    bit            m_val [2];
    bit            busy, m_gnt, m_last, m_err, pa, pb, cs_i;
    int            hold, wcnt;
    logic [AW-1:0] m_addr;

    function automatic bit mok(input int i);
        return i ? (b_cs & m_val[1] & (b_addr == m_tag[1]))
                 : (a_cs & m_val[0] & (a_addr == m_tag[0]));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                m_tag[i] = '0; m_dat[i] = '0; m_val[i] = 0;
            end
            busy = 0; m_gnt = 0; m_last = 1; m_err = 0; hold = 0; wcnt = 0; m_addr = '0;
        end else begin
            pa = a_cs & !mok(0);
            pb = b_cs & !mok(1);
            for (int i = 0; i < 2; i++) begin
                cs_i = i ? b_cs : a_cs;
                if (busy && rom_ok && int'(m_gnt) == i) begin
                    m_tag[i] = m_addr; m_dat[i] = rom_data; m_val[i] = cs_i;
                end else if (!cs_i) m_val[i] = 0;
            end
            if (busy) begin
                if (rom_ok) begin
                    busy = 0; hold = 1; m_last = m_gnt;
                end
`ifdef JTKUNIO_ROMARB_WDOG_EN
                else if (wcnt == 255) begin
                    busy = 0; hold = 1; m_last = m_gnt; m_err = 1;
                end else wcnt++;
`endif
            end else if (hold > 0) hold--;
            else if (pa || pb) begin
                m_gnt  = (pa && pb) ? !m_last : pb;
                m_addr = m_gnt ? b_addr : a_addr;
                busy   = 1;
                wcnt   = 0;
            end
        end
    end

    always @(negedge clk) if (checking) begin
        chk("a_ok", a_ok, mok(0));
        chk("b_ok", b_ok, mok(1));
        chk("a_data", a_data, m_dat[0]);
        chk("b_data", b_data, m_dat[1]);
        chk("rom_cs", rom_cs, busy);
        chk("rom_addr", rom_addr, m_addr);
        chk("err", err, m_err);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cs();
        int n = 0;
        while (!rom_cs && n < 20) begin
            cyc();
            n++;
        end
        if (!rom_cs) chk("rom_cs_timeout", 0, 1);
    endtask

    task automatic serve(input logic [AW-1:0] ea, input logic [DW-1:0] d);
        wait_cs();
        chk("grant_addr", rom_addr, ea);
        cyc();
        rom_ok = 1; rom_data = d;
        cyc();
        rom_ok = 0;
    endtask

    task automatic do_reset();
        rst = 1; a_cs = 0; b_cs = 0; rom_ok = 0;
        cyc(); cyc();
        rst = 0;
    endtask

    initial begin
        cyc(); cyc();
        checking = 1;
        rst = 0;
        // single requester, then an address switch with cs held
        a_addr = 18'h00100; a_cs = 1;
        cyc(); #1;
        chk("t1_rom_cs", rom_cs, 1);
        chk("t1_rom_addr", rom_addr, 18'h00100);
        cyc();
        rom_ok = 1; rom_data = 32'hDEADBEEF;
        cyc();
        rom_ok = 0; #1;
        chk("t1_a_ok", a_ok, 1);
        chk("t1_a_data", a_data, 32'hDEADBEEF);
        chk("t1_gap", rom_cs, 0);
        cyc();
        chk("t1_idle", rom_cs, 0);
        a_addr = 18'h30100; #1;
        chk("t3_ok_drop", a_ok, 0);
        serve(18'h30100, 32'hCAFEF00D); #1;
        chk("t3_a_ok", a_ok, 1);
        chk("t3_a_data", a_data, 32'hCAFEF00D);
        a_cs = 0;
        cyc(); cyc();
        // tie from reset alternates starting with A
        do_reset();
        a_addr = 18'h00010; b_addr = 18'h20000; a_cs = 1; b_cs = 1;
        serve(18'h00010, 32'h11111111);
        serve(18'h20000, 32'h22222222);
        a_addr = 18'h00011; b_addr = 18'h20001;
        serve(18'h00011, 32'h33333333);
        serve(18'h20001, 32'h44444444); #1;
        chk("t2_b_data", b_data, 32'h44444444);
        a_cs = 0; b_cs = 0;
        // B drops cs mid-transfer: data discarded
        do_reset();
        b_addr = 18'h20000; b_cs = 1;
        cyc();
        b_cs = 0;
        cyc();
        rom_ok = 1; rom_data = 32'h55555555;
        cyc();
        rom_ok = 0; b_cs = 1; #1;
        chk("t4_b_ok", b_ok, 0);
        serve(18'h20000, 32'h66666666); #1;
        chk("t4_b_ok_after", b_ok, 1);
        b_cs = 0;
        // reset during BUSY
        do_reset();
        a_addr = 18'h00200; a_cs = 1;
        cyc();
        rst = 1; #1;
        chk("t5_rom_cs", rom_cs, 0);
        chk("t5_a_ok", a_ok, 0);
        chk("t5_b_ok", b_ok, 0);
        a_cs = 0;
        cyc();
        rst = 0; rom_ok = 1; rom_data = 32'h77777777;
        cyc(); cyc();
        rom_ok = 0; #1;
        chk("t5_rom_cs_after", rom_cs, 0);
        a_cs = 1; #1;
        chk("t5_a_ok_after", a_ok, 0);
        a_cs = 0;
        cyc();
        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            a_cs = ($urandom % 4) != 0;
            b_cs = ($urandom % 4) != 0;
            if ($urandom % 4 == 0) a_addr = AW'($urandom_range(0, 3)) << 8;
            if ($urandom % 4 == 0) b_addr = AW'($urandom_range(0, 3)) << 12;
            rom_ok = ($urandom % 3) == 0;
            rom_data = $urandom;
            rst = ($urandom % 500) == 0;
            cyc();
        end
        rst = 0;
`ifdef JTKUNIO_ROMARB_WDOG_EN
        do_reset();
        a_addr = 18'h00300; a_cs = 1;
        for (int k = 0; k < 300 && !err; k++) cyc();
        chk("wd_err", err, 1);
        chk("wd_rom_cs", rom_cs, 0);
        a_cs = 0;
        repeat (5) cyc();
        chk("wd_sticky", err, 1);
`endif
        do_reset();
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
